// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory initiator: access sizes, FSM states, lane-enable patterns.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] BT_WORD    = 4'b1111;
  localparam logic [3:0] BT_HALF_LO = 4'b0011;
  localparam logic [3:0] BT_HALF_HI = 4'b1100;
  localparam logic [3:0] BT_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: lane enables and misalignment for a request, lane select plus
// sign/zero extension for a read word. Zero latency, no flow control.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  bit_type_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      2'd3:    byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    bit_type_o = '0;
    misalign_o = 1'b0;
    rdata_o    = '0;
    case (size_i)
      SZ_BYTE: begin
        bit_type_o = BT_BYTE0 << addr_lo_i;
        rdata_o    = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        bit_type_o = addr_lo_i[1] ? BT_HALF_HI : BT_HALF_LO;
        rdata_o    = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign_o = |addr_lo_i;
        bit_type_o = BT_WORD;
        rdata_o    = rword_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the data memory; response 2 cycles after accept
// (1 for misaligned/illegal). req_ready only in IDLE; the response pulse cannot be stalled.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_exc,
  output logic [31:0]       dm_pc,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_bit_type,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata
);

  state_e            state_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        addr_lo_q;
  logic              resp_valid_q;
  logic              resp_exc_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [31:0]       dm_pc_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [3:0]        dm_bt_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic              dm_we_q;

  logic        idle;
  logic [1:0]  al_size;
  logic        al_sgn;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_bt;
  logic        al_misalign;
  logic [31:0] al_rdata;

  // One aligner serves both phases: live request fields in IDLE, latched fields afterwards.
  assign idle       = (state_q == ST_IDLE);
  assign al_size    = idle ? req_size : size_q;
  assign al_sgn     = idle ? req_signed : sgn_q;
  assign al_addr_lo = idle ? req_addr[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .size_i     (al_size),
    .signed_i   (al_sgn),
    .addr_lo_i  (al_addr_lo),
    .rword_i    (dm_rdata),
    .bit_type_o (al_bt),
    .misalign_o (al_misalign),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      sgn_q        <= 1'b0;
      addr_lo_q    <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_exc_q   <= 1'b0;
      resp_rdata_q <= '0;
      dm_pc_q      <= '0;
      dm_addr_q    <= '0;
      dm_bt_q      <= '0;
      dm_wdata_q   <= '0;
      dm_we_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            size_q    <= req_size;
            sgn_q     <= req_signed;
            addr_lo_q <= req_addr[1:0];
            dm_pc_q   <= req_pc;
            if (al_misalign) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_exc_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q    <= ST_ACCESS;
              dm_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              dm_wdata_q <= req_wdata;
              dm_bt_q    <= al_bt;
              dm_we_q    <= req_write;
            end
          end
        end
        ST_ACCESS: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_exc_q   <= 1'b0;
          resp_rdata_q <= wr_q ? '0 : al_rdata;
          dm_bt_q      <= '0;
          dm_we_q      <= 1'b0;
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_exc_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = idle;
  assign resp_valid  = resp_valid_q;
  assign resp_exc    = resp_exc_q;
  assign resp_rdata  = resp_rdata_q;
  assign dm_pc       = dm_pc_q;
  assign dm_addr     = dm_addr_q;
  assign dm_bit_type = dm_bt_q;
  assign dm_wdata    = dm_wdata_q;
  // A reset asserted mid-ACCESS must suppress the write in that same cycle.
  assign dm_we       = dm_we_q & reset;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory port: takes one load/store request at a time from the pipeline MEM stage and drives the word-addressed, lane-enabled data memory (`Addr`/`Bit_Type`/`WriteData`/`WriteEnabled`/`ReadData`). Returns aligned, sign- or zero-extended load data and a misalignment flag to the pipeline. Sits between the MEM stage and the data memory; one access is in flight at a time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (only 32 supported)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset)
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_signed`  in  1  loads: 1 = sign-extend, 0 = zero-extend
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-justified
- `req_pc`  in  32  PC of the issuing instruction (trace only)
- `resp_valid`  out  1  one-cycle pulse, response present
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and exceptions
- `resp_exc`  out  1  misaligned or illegal size; valid with `resp_valid`
- `dm_pc`  out  32  latched `req_pc`
- `dm_addr`  out  ADDR_W  `{addr[31:2],2'b00}`
- `dm_bit_type`  out  4  lane enables
- `dm_wdata`  out  DATA_W  store data, unshifted
- `dm_we`  out  1  write strobe
- `dm_rdata`  in  DATA_W  combinational read word from memory

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready=1`. Handshake when `req_valid&&req_ready` at an edge: latch write/size/signed/addr/wdata/pc.
  - Aligned (byte; half with addr[0]=0; word with addr[1:0]=0) -> ACCESS.
  - Misaligned or size 11 -> RESP with `resp_exc=1`; memory untouched.
- ACCESS (exactly one cycle): drive `dm_addr`, `dm_bit_type`, `dm_wdata=req_wdata`, `dm_we=req_write`. Memory takes low-order data for every lane pattern, so no shifting on stores.
  - `dm_bit_type`: word 1111; half 0011 (addr[1]=0) or 1100 (addr[1]=1); byte `4'b0001 << addr[1:0]`.
  - Loads: capture `dm_rdata` at the closing edge. Select byte `addr[1:0]` or half `addr[1]`. Extend to 32 bits per `req_signed`. Register into `resp_rdata`.
  - -> RESP.
- RESP: `resp_valid=1` for one cycle -> IDLE. Response is not back-pressured; the pipeline must take it.
- Outside ACCESS: `dm_we=0`, `dm_bit_type=0000`, `dm_addr`/`dm_wdata` hold last value.
- Extension: byte signed uses bit 7; half signed uses bit 15; word ignores `req_signed`.

## Timing
- Reset values (cycle after `reset=0` sampled): state IDLE, `req_ready=1`, `resp_valid=0`, `resp_exc=0`, `resp_rdata=0`, `dm_we=0`, `dm_bit_type=0`, `dm_addr=0`, `dm_wdata=0`, `dm_pc=0`.
- Accept at edge N. ACCESS during cycle N+1. `resp_valid` high during cycle N+2. `req_ready` high again in N+3. Throughput is 1 request per 3 cycles.
- Exception path: accept at N, `resp_valid`+`resp_exc` during N+1, `req_ready` in N+2.
- `dm_we` is gated by `reset`: no write occurs in a cycle where `reset=0`, including reset mid-ACCESS. Reset in ACCESS or RESP aborts with no response.
- `req_*` inputs are ignored outside the IDLE handshake.

## Structure
- Package `mem_access_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum, lane constants (`BT_WORD=1111`, `BT_HALF_LO=0011`, `BT_HALF_HI=1100`, `BT_BYTE0=0001`).
- Sub-module `mem_lane_align` (combinational):
  - Inputs: size, signed, addr[1:0], read word.
  - Outputs: bit_type, misalign flag, extended load data.
- The top level holds the FSM and the request/response registers.

## Test plan
- Store word 0xDEADBEEF @0x100, then load word @0x100 -> `dm_bit_type=1111`, `dm_we` pulses exactly one cycle, `resp_rdata=0xDEADBEEF`, `resp_valid` at N+2.
- Store byte 0x80 @0x103 over 0x00000000, then load byte signed @0x103 -> `dm_bit_type=1000`, memory word 0x80000000, `resp_rdata=0xFFFFFF80`. Repeat unsigned -> 0x00000080.
- Load half signed @0x102 from word 0x8001_7FFF -> `resp_rdata=0xFFFF8001`. Load half @0x100 -> 0x00007FFF.
- Load word @0x102, store half @0x101, and size 11 @0x100 -> each gives `resp_exc=1`, `resp_rdata=0`, `dm_we` never asserted, response at N+1.
- Hold `req_valid` high with back-to-back requests -> `req_ready` low for two cycles after each accept, and no request is lost or duplicated.
- Drive `reset=0` during ACCESS of a store -> `dm_we=0` that cycle, memory unchanged, no `resp_valid`, IDLE with all outputs at reset values next cycle.
